// File: rtl/fpa_pkg.sv
// Shared types and constants for the floating-point adder normalizer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpa_pkg;

  localparam int EXP_WIDTH      = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int BIAS           = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int RESULT_WIDTH   = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  // Quiet NaN: positive, all-ones exponent, only the fraction MSB set.
  localparam logic [RESULT_WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

  // Infinity magnitude; the sign bit is prepended by the user.
  localparam logic [RESULT_WIDTH-2:0] INF_MAG =
    {{EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};

  // Raw adder result: mant = {carry, hidden, fraction, guard, round}.
  typedef struct packed {
    logic                      sign;
    logic [EXP_WIDTH-1:0]      exp;
    logic [MANTISSA_WIDTH+3:0] mant;
    logic                      sticky;
    logic                      nan;
    logic                      inf;
  } raw_sum_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fpa_flags_t;

endpackage

// File: rtl/fpa_lzc.sv
// Leading-zero counter; count = WIDTH when the input is all zero.
// Latency: combinational.
// Backpressure: none.
// Ports: data (WIDTH) in; count (CNT_WIDTH) and all_zero out.
module fpa_lzc
  import fpa_pkg::*;
#(
  parameter int WIDTH     = MANTISSA_WIDTH + 3,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     data,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 all_zero
);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_WIDTH'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/fpa_normalizer.sv
// Normalize, round-to-nearest-even and pack a raw adder sum into IEEE-754.
// Latency: 2 cycles (stage 1 normalize, stage 2 round/pack/flags).
// Backpressure: valid/ready; each stage loads when empty or draining, output holds while stalled.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with in_sign, in_exp, in_mant,
//        in_sticky, in_nan, in_inf; out_valid/out_ready with out_result and the three flags.
module fpa_normalizer #(
  parameter int EXP_WIDTH      = fpa_pkg::EXP_WIDTH,
  parameter int MANTISSA_WIDTH = fpa_pkg::MANTISSA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sign,
  input  logic [EXP_WIDTH-1:0]              in_exp,
  input  logic [MANTISSA_WIDTH+3:0]         in_mant,
  input  logic                              in_sticky,
  input  logic                              in_nan,
  input  logic                              in_inf,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] out_result,
  output logic                              out_overflow,
  output logic                              out_underflow,
  output logic                              out_inexact
);
  import fpa_pkg::*;

  localparam int MW = MANTISSA_WIDTH;
  localparam int EW = EXP_WIDTH;
  localparam int NW = MW + 3;            // {hidden, fraction, guard, round}
  localparam int CW = $clog2(NW + 1);
  localparam int XW = EW + 2;            // two's-complement exponent, cannot wrap
  localparam int RW = 1 + EW + MW;

  localparam logic [RW-1:0] QNAN_W    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [RW-2:0] INF_MAG_W = {{EW{1'b1}}, {MW{1'b0}}};
  localparam logic [XW-1:0] EXP_MAX   = XW'((1 << EW) - 1);

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s1_adv;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign in_ready = rst_n && (!s1_valid || s1_adv);

  // ---------------- stage 1: normalize ----------------
  logic [CW-1:0] lz;
  logic          lz_zero;
  logic          carry;
  logic          mant_zero;
  logic [XW-1:0] exp_ext;
  logic [XW-1:0] n1_exp;
  logic [NW-2:0] n1_mant;    // hidden bit dropped: it is implicitly 1 on the arithmetic path
  logic          n1_sticky;
  logic          n1_zero;
  logic          n1_uf;

  fpa_lzc #(
    .WIDTH     (NW),
    .CNT_WIDTH (CW)
  ) u_lzc (
    .data     (in_mant[NW-1:0]),
    .count    (lz),
    .all_zero (lz_zero)
  );

  assign carry     = in_mant[NW];
  assign mant_zero = !carry && lz_zero;
  assign exp_ext   = {2'b00, in_exp};

  always_comb begin
    if (carry) begin
      // Shift right one: the carry becomes the hidden bit, round falls into sticky.
      n1_mant   = in_mant[NW-1:1];
      n1_sticky = in_sticky | in_mant[0];
      n1_exp    = exp_ext + XW'(1);
    end else begin
      n1_mant   = (NW-1)'(in_mant[NW-1:0] << lz);
      n1_sticky = in_sticky;
      n1_exp    = exp_ext - XW'(lz);
    end
    n1_zero = mant_zero && !in_sticky;
    // Sticky-only residue, a zero input exponent, or a non-positive result all flush.
    n1_uf   = !n1_zero && (mant_zero || (in_exp == '0) ||
                           n1_exp[XW-1] || (n1_exp == '0));
  end

  logic          s1_sign;
  logic [XW-1:0] s1_exp;
  logic [NW-2:0] s1_mant;
  logic          s1_sticky;
  logic          s1_nan;
  logic          s1_inf;
  logic          s1_zero;
  logic          s1_uf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_sign   <= in_sign;
      s1_exp    <= n1_exp;
      s1_mant   <= n1_mant;
      s1_sticky <= n1_sticky;
      s1_nan    <= in_nan;
      s1_inf    <= in_inf;
      s1_zero   <= n1_zero;
      s1_uf     <= n1_uf;
    end
  end

  // ---------------- stage 2: round, pack, flag ----------------
  logic          g_bit;
  logic          r_bit;
  logic          round_up;
  logic [MW:0]   frac_sum;   // MSB is the rounding carry-out
  logic [XW-1:0] exp_f;
  logic [RW-1:0] res_d;
  fpa_flags_t    flags_d;

  always_comb begin
    g_bit    = s1_mant[1];
    r_bit    = s1_mant[0];
    round_up = g_bit & (r_bit | s1_sticky | s1_mant[2]);
    frac_sum = {1'b0, s1_mant[MW+1:2]} + (MW+1)'(round_up);
    // On carry-out the low MW bits of frac_sum are already zero.
    exp_f    = s1_exp + XW'(frac_sum[MW]);

    res_d   = '0;
    flags_d = '0;
    if (s1_nan) begin
      res_d = QNAN_W;
    end else if (s1_inf) begin
      res_d = {s1_sign, INF_MAG_W};
    end else if (s1_zero) begin
      res_d = '0;
    end else if (s1_uf) begin
      res_d             = {s1_sign, {(RW-1){1'b0}}};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else if (exp_f >= EXP_MAX) begin
      res_d            = {s1_sign, INF_MAG_W};
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end else begin
      res_d           = {s1_sign, exp_f[EW-1:0], frac_sum[MW-1:0]};
      flags_d.inexact = g_bit | r_bit | s1_sticky;
    end
  end

  fpa_flags_t out_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_d;
        out_flags  <= flags_d;
      end
    end
  end

  assign out_overflow  = out_flags.overflow;
  assign out_underflow = out_flags.underflow;
  assign out_inexact   = out_flags.inexact;

endmodule

// File: tb/tb_fpa_normalizer.sv
// Self-checking bench for fpa_normalizer: directed vectors, backpressure,
// mid-stream reset and randomized back-to-back traffic against a scoreboard.
module tb_fpa_normalizer;
  import fpa_pkg::*;

  localparam int MW = MANTISSA_WIDTH;
  localparam int EW = EXP_WIDTH;
  localparam int RW = 1 + EW + MW;
  localparam logic [EW-1:0] B = EW'(BIAS);
  localparam int ND = 18;

  typedef struct packed {
    logic [RW-1:0] res;
    fpa_flags_t    flg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic          out_overflow;
  logic          out_underflow;
  logic          out_inexact;
  raw_sum_t      cur;

  exp_t     sb[$];
  raw_sum_t dv[ND];
  exp_t     de[ND];
  int       vectors     = 0;
  int       miscompares = 0;

  always #5 clk = ~clk;

  fpa_normalizer #(
    .EXP_WIDTH      (EW),
    .MANTISSA_WIDTH (MW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (cur.sign),
    .in_exp        (cur.exp),
    .in_mant       (cur.mant),
    .in_sticky     (cur.sticky),
    .in_nan        (cur.nan),
    .in_inf        (cur.inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  function automatic raw_sum_t rs(input logic s, input logic [EW-1:0] e,
                                  input logic [MW+3:0] m, input logic st,
                                  input logic n, input logic i);
    raw_sum_t v;
    v.sign = s; v.exp = e; v.mant = m; v.sticky = st; v.nan = n; v.inf = i;
    return v;
  endfunction

  function automatic exp_t ex(input logic [RW-1:0] r, input logic [2:0] f);
    exp_t e;
    e.res = r;
    e.flg = f;
    return e;
  endfunction

  // Reference: align the leading one to bit 63, then slice significand/guard/rest.
  function automatic exp_t model(input raw_sum_t x);
    exp_t          e;
    logic [63:0]   al;
    logic [MW+1:0] sig;
    logic          g;
    logic          rest;
    int            p;
    int            xp;
    e.res = '0;
    e.flg = '0;
    if (x.nan) begin e.res = QNAN; return e; end
    if (x.inf) begin e.res = {x.sign, INF_MAG}; return e; end
    if (x.mant == '0 && !x.sticky) return e;
    p = -1;
    for (int i = 0; i < MW + 4; i++) if (x.mant[i]) p = i;
    xp = int'(x.exp) + p - (MW + 2);
    if (p < 0 || x.exp == '0 || xp <= 0) begin
      e.res = {x.sign, {(RW-1){1'b0}}};
      e.flg = 3'b011;
      return e;
    end
    al   = 64'(x.mant) << (63 - p);
    sig  = {1'b0, al[63 -: MW+1]};
    g    = al[62-MW];
    rest = (|al[61-MW:0]) | x.sticky;
    if (g && (rest || sig[0])) sig = sig + 1'b1;
    if (sig[MW+1]) begin sig = sig >> 1; xp++; end
    if (xp >= (1 << EW) - 1) begin
      e.res = {x.sign, INF_MAG};
      e.flg = 3'b101;
      return e;
    end
    e.res = {x.sign, xp[EW-1:0], sig[MW-1:0]};
    e.flg = {2'b00, g | rest};
    return e;
  endfunction

  // Offer one item until accepted; push its expectation on acceptance.
  task automatic send(input raw_sum_t v, input exp_t e, output bit ok);
    cur      = v;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(e);
    else begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready never seen, required 1");
    end
  endtask

  task automatic build_table();
    dv[0]  = rs(1'b0, B,     27'h4000000, 1'b0, 1'b0, 1'b0); de[0]  = ex(32'h40000000, 3'b000);
    dv[1]  = rs(1'b0, B,     27'h2000006, 1'b0, 1'b0, 1'b0); de[1]  = ex(32'h3F800002, 3'b001);
    dv[2]  = rs(1'b0, B,     27'h2000002, 1'b0, 1'b0, 1'b0); de[2]  = ex(32'h3F800000, 3'b001);
    dv[3]  = rs(1'b0, B,     27'h06AF378, 1'b0, 1'b0, 1'b0); de[3]  = ex(32'h3E55E6F0, 3'b000);
    dv[4]  = rs(1'b0, 8'd254, 27'h4000000, 1'b0, 1'b0, 1'b0); de[4] = ex(32'h7F800000, 3'b101);
    dv[5]  = rs(1'b0, 8'd3,  27'h0100000, 1'b0, 1'b0, 1'b0); de[5]  = ex(32'h00000000, 3'b011);
    dv[6]  = rs(1'b1, B,     27'h2000000, 1'b0, 1'b1, 1'b0); de[6]  = ex(32'h7FC00000, 3'b000);
    dv[7]  = rs(1'b1, B,     27'h2000000, 1'b0, 1'b0, 1'b1); de[7]  = ex(32'hFF800000, 3'b000);
    dv[8]  = rs(1'b1, B,     27'h2000000, 1'b0, 1'b1, 1'b1); de[8]  = ex(32'h7FC00000, 3'b000);
    dv[9]  = rs(1'b1, 8'd50, 27'h0000000, 1'b0, 1'b0, 1'b0); de[9]  = ex(32'h00000000, 3'b000);
    dv[10] = rs(1'b0, B,     27'h3FFFFFF, 1'b0, 1'b0, 1'b0); de[10] = ex(32'h40000000, 3'b001);
    dv[11] = rs(1'b0, B,     27'h2000002, 1'b1, 1'b0, 1'b0); de[11] = ex(32'h3F800001, 3'b001);
    dv[12] = rs(1'b0, B,     27'h6000001, 1'b0, 1'b0, 1'b0); de[12] = ex(32'h40400000, 3'b001);
    dv[13] = rs(1'b1, 8'd130, 27'h2000000, 1'b0, 1'b0, 1'b0); de[13] = ex(32'hC1000000, 3'b000);
    dv[14] = rs(1'b1, 8'd0,  27'h2000000, 1'b0, 1'b0, 1'b0); de[14] = ex(32'h80000000, 3'b011);
    dv[15] = rs(1'b0, 8'd254, 27'h3FFFFFF, 1'b0, 1'b0, 1'b0); de[15] = ex(32'h7F800000, 3'b101);
    dv[16] = rs(1'b0, 8'd3,  27'h0400000, 1'b0, 1'b0, 1'b0); de[16] = ex(32'h00000000, 3'b011);
    dv[17] = rs(1'b0, 8'd4,  27'h0400000, 1'b0, 1'b0, 1'b0); de[17] = ex(32'h00800000, 3'b000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cur = rs(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, out_result, out_overflow, out_underflow, out_inexact} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b ready=%b res=%h flags=%b%b%b required all 0",
               out_valid, in_ready, out_result, out_overflow, out_underflow, out_inexact);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    bit   ok;
    bit   got;
    int   lat;
    exp_t x;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < ND; i++) begin
      send(dv[i], de[i], ok);
      if (ok) begin
        lat = 0; got = 1'b0;
        while (!got && lat < 10) begin
          @(negedge clk); lat++;
          if (out_valid) got = 1'b1;
        end
        vectors++;
        if (lat !== 2) begin
          miscompares++;
          $display("FAIL latency[%0d]: got %0d cycles required 2", i, lat);
        end
        if (got) begin
          x = sb.pop_front();
          vectors++;
          if ({out_result, out_overflow, out_underflow, out_inexact} !== x) begin
            miscompares++;
            $display("FAIL directed[%0d]: got %h/%b%b%b required %h/%b", i, out_result,
                     out_overflow, out_underflow, out_inexact, x.res, x.flg);
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int   idx;
    int   got;
    bit   take;
    exp_t x;
    sb.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cur = dv[idx]; in_valid = 1'b1;
      @(negedge clk);
      take = in_ready;
      @(posedge clk); #1;
      if (take) begin sb.push_back(de[idx]); idx++; end
    end
    @(negedge clk);
    vectors++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: accepted %0d in_ready=%b required 2/0", idx, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || {out_result, out_overflow, out_underflow, out_inexact} !== de[0]) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b res=%h required 1/%h", c, out_valid, out_result, de[0].res);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) cur = dv[idx];
      @(negedge clk);
      take = in_valid && in_ready;
      if (out_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bp_order: unexpected output %h required none", out_result);
        end else begin
          x = sb.pop_front();
          if ({out_result, out_overflow, out_underflow, out_inexact} !== x) begin
            miscompares++;
            $display("FAIL bp_order[%0d]: got %h required %h", got, out_result, x.res);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      if (take) begin sb.push_back(de[idx]); idx++; end
    end
    in_valid = 1'b0;
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d outputs required 4", got);
    end
  endtask

  task automatic test_reset_midstream();
    bit   ok;
    bit   got;
    int   ghosts;
    exp_t x;
    sb.delete();
    out_ready = 1'b0;
    send(dv[1], de[1], ok);
    send(dv[2], de[2], ok);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready_low: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_flush: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    ghosts = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    vectors++;
    if (ghosts !== 0) begin
      miscompares++;
      $display("FAIL rst_ghost: %0d stale outputs required 0", ghosts);
    end
    @(posedge clk); #1;
    send(dv[13], de[13], ok);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    vectors++;
    if (!got || sb.size() == 0) begin
      miscompares++;
      $display("FAIL rst_resume: out_valid=%b required 1", out_valid);
    end else begin
      x = sb.pop_front();
      if ({out_result, out_overflow, out_underflow, out_inexact} !== x) begin
        miscompares++;
        $display("FAIL rst_resume: got %h required %h", out_result, x.res);
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic raw_sum_t rnd_sum();
    raw_sum_t    v;
    logic [31:0] t;
    t        = $urandom;
    v.mant   = t[MW+3:0];
    if ($urandom_range(0, 1) == 1) v.mant = v.mant >> $urandom_range(1, MW + 4);
    t        = $urandom;
    v.sign   = t[0];
    v.sticky = t[1];
    v.exp    = t[EW+1:2];
    v.nan    = ($urandom_range(0, 31) == 0);
    v.inf    = ($urandom_range(0, 31) == 0);
    return v;
  endfunction

  task automatic test_back_to_back();
    localparam int N = 200;
    sb.delete();
    out_ready = 1'b1;
    fork
      begin
        bit       ok;
        raw_sum_t v;
        for (int i = 0; i < N; i++) begin
          v = rnd_sum();
          send(v, model(v), ok);
        end
      end
      begin
        int   got;
        exp_t x;
        got = 0;
        for (int c = 0; c < 5000 && got < N; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL b2b_ghost: output %h with empty scoreboard", out_result);
            end else begin
              x = sb.pop_front();
              if ({out_result, out_overflow, out_underflow, out_inexact} !== x) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h/%b%b%b required %h/%b", got, out_result,
                         out_overflow, out_underflow, out_inexact, x.res, x.flg);
              end
            end
            got++;
          end
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        vectors++;
        if (got !== N) begin
          miscompares++;
          $display("FAIL b2b_count: got %0d outputs required %0d", got, N);
        end
      end
    join
    out_ready = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpa_normalizer.md
FPA_NORMALIZER -- requirements
Module: fpa_normalizer

Interface
REQ-001 Parameter EXP_WIDTH, default 8, sets the biased exponent width.
REQ-002 Parameter MANTISSA_WIDTH, default 23, sets the stored fraction width; the hidden bit is extra.
REQ-003 Clocking: one clock, clk; reset rst_n, synchronous, active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  raw adder result is presented.
REQ-007 in_ready  output  1  the stage accepts input this cycle.
REQ-008 in_sign  input  1  sign of the raw sum.
REQ-009 in_exp  input  EXP_WIDTH  biased exponent aligned to the hidden-bit position.
REQ-010 in_mant  input  MANTISSA_WIDTH+4  fields are {carry, hidden, fraction[MANTISSA_WIDTH-1:0], guard, round}.
REQ-011 in_sticky  input  1  OR of all bits shifted out below round.
REQ-012 in_nan / in_inf  input  1 each  special-operand result flags from the adder core.
REQ-013 out_valid  output  1  result is valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_result  output  1+EXP_WIDTH+MANTISSA_WIDTH  packed IEEE-754 result.
REQ-016 out_overflow / out_underflow / out_inexact  output  1 each  exception flags qualified by out_valid.

Function
REQ-017 Pipeline: 2 register stages; latency is exactly 2 cycles from the in_valid&in_ready transfer to out_valid while out_ready=1.
REQ-018 Stage 1 normalizes: LZC, shift and exponent adjust. Stage 2 rounds, packs and flags.
REQ-019 Handshake: each stage loads when it is empty or its contents leave this cycle.
REQ-020 in_ready = !s1_valid || s1 advancing; data is never dropped or duplicated, and order is preserved.
REQ-021 Output stability: out_result and the flags hold stable while out_valid=1 and out_ready=0.
REQ-022 Carry=1: shift mantissa right 1; exp+1; the old round bit ORs into sticky.
REQ-023 Carry=0 and hidden=0: shift left by the leading-zero count of {hidden..round}; exp-lz.
REQ-024 Underflow: if exp-lz<=0, or exp=0 with a nonzero mantissa, flush to signed zero with out_underflow=1 and out_inexact=1; no subnormals are produced.
REQ-025 Exact zero: an all-zero mantissa with sticky=0 gives +0 and no flags.
REQ-026 Rounding is round-to-nearest-even: round_up = G & (R | S | LSB).
REQ-027 out_inexact = G|R|S after normalization.
REQ-028 Rounding carry-out: if the fraction rounds past all-ones, exp+1 and fraction=0.
REQ-029 Overflow: a final exp >= 2^EXP_WIDTH-1 gives signed infinity with out_overflow=1 and out_inexact=1.
REQ-030 Priority: in_nan > in_inf > arithmetic path.
- in_nan gives quiet NaN {0, all-ones exponent, MSB-only fraction}.
- in_inf gives signed infinity.
- Special cases assert no flags.
REQ-031 Exponent arithmetic is done in EXP_WIDTH+2 signed bits, so wrap-around is impossible.

Reset
REQ-032 While rst_n=0 at a clk edge:
- s1_valid, out_valid, out_result and all flags clear to 0.
- in_ready reads 0 during reset and 1 on the first cycle after release.
REQ-033 Reset mid-operation discards all in-flight items; no stale output appears after release.

Structure
REQ-034 Shared package fpa_pkg holds:
- EXP_WIDTH, MANTISSA_WIDTH, BIAS;
- QNAN/INF constants;
- typedef struct raw_sum_t (sign, exp, mant, sticky, nan, inf);
- typedef struct fpa_flags_t.
REQ-035 One sub-module, fpa_lzc: a combinational leading-zero counter over MANTISSA_WIDTH+3 bits.
- Output: count, plus an all-zero indicator.

Verification
REQ-036 Carry case:
- Stimulus: carry=1, hidden=0, frac=0, exp=127, G=R=S=0 (1.0+1.0).
- Response: 0x40000000 after 2 cycles, no flags.
REQ-037 RNE:
- Tie with odd LSB: hidden=1, frac=0x000001, exp=127, G=1, R=S=0 gives 0x3F800002, inexact.
- Tie with even LSB: frac=0, G=1 gives 0x3F800000, inexact.
REQ-038 Cancellation:
- Stimulus: hidden=0, leading one 3 positions below hidden, exp=127.
- Response: exponent field 124, fraction correctly left-shifted, no flags.
REQ-039 Overflow/underflow:
- Carry=1, exp=254 gives 0x7F800000 with overflow.
- lz=5 with exp=3 gives 0x00000000 with underflow.
- in_nan=1 gives 0x7FC00000.
REQ-040 Backpressure:
- Stimulus: out_ready=0 for 4 cycles while 4 back-to-back inputs are offered.
- Response: exactly 2 accepted, then in_ready=0; after release all results emerge in order, unchanged while stalled.
REQ-041 Reset mid-stream:
- Stimulus: rst_n=0 for 1 cycle with 2 items in flight.
- Response: out_valid=0 next cycle, no ghost outputs, and normal operation on the next input.
